// File: rtl/tinyarch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tinyarch_pkg
// Brief    : Shared widths and program-1 operand/result byte addresses.
// Revision : 1.0
// ============================================================================
package tinyarch_pkg;

  localparam int DW = 8;
  localparam int AW = 8;

  // Program 1: 16-bit integer in, 16-bit float out, MSB at the higher address
  localparam logic [AW-1:0] P1_IN_LO  = AW'(0);
  localparam logic [AW-1:0] P1_IN_HI  = AW'(1);
  localparam logic [AW-1:0] P1_OUT_LO = AW'(2);
  localparam logic [AW-1:0] P1_OUT_HI = AW'(3);

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Brief    : Single-port byte memory, synchronous write, combinational read.
// Revision : 1.0
// ============================================================================
module data_memory
  import tinyarch_pkg::*;
#(
  parameter int    DW        = tinyarch_pkg::DW,
  parameter int    AW        = tinyarch_pkg::AW,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] DataAddress,
  input  logic          ReadMem,
  input  logic          WriteMem,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut
);

  localparam int c_DEPTH = 2 ** AW;

  // Benches poke this array hierarchically, so it stays at top level and
  // reset deliberately leaves it untouched.
  logic [DW-1:0] mem_core [0:c_DEPTH-1];

  // Read strobe is advisory; reads are always live.
  logic w_unused_readmem;
  assign w_unused_readmem = ReadMem;

  always @(posedge clk) begin
    if (WriteMem && !reset) begin
      mem_core[DataAddress] <= DataIn;
    end
  end

  assign DataOut = mem_core[DataAddress];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (WriteMem && !reset) begin
      a_wr_addr_known: assert (!$isunknown(DataAddress))
        else $error("data_memory: write with unknown address");
      a_wr_data_known: assert (!$isunknown(DataIn))
        else $error("data_memory: write with unknown data");
    end
  end
`endif

`ifdef TRACE
  always @(posedge clk) begin
    if (WriteMem && !reset) begin
      $display("%0t data_memory write [%02h] <= %02h", $time, DataAddress, DataIn);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Brief    : Directed self-checking bench for data_memory.
// Revision : 1.0
// ============================================================================
module tb_data_memory;
  import tinyarch_pkg::*;

  logic          clk;
  logic          reset;
  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;

  int checks   = 0;
  int failures = 0;

  data_memory #(
    .DW       (DW),
    .AW       (AW),
    .INIT_FILE("")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .DataAddress(DataAddress),
    .ReadMem    (ReadMem),
    .WriteMem   (WriteMem),
    .DataIn     (DataIn),
    .DataOut    (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive a write, take one edge, then sample 1 time unit after the edge.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    DataAddress = a;
    DataIn      = d;
    WriteMem    = 1'b1;
    @(posedge clk);
    #1;
    WriteMem    = 1'b0;
  endtask

  task automatic read_at(input logic [AW-1:0] a, input string tag, input logic [DW-1:0] exp);
    DataAddress = a;
    #1;
    check(tag, DataOut, exp);
  endtask

  initial begin
    reset       = 1'b1;
    DataAddress = '0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = '0;

    // Contents preloaded before reset must be visible during reset
    dut.mem_core[0] = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    read_at(8'h00, "reset_read_preload", 8'h34);
    reset = 1'b0;

    // Basic write/read with both ReadMem levels
    write_word(8'h10, 8'hA5);
    ReadMem = 1'b0;
    read_at(8'h10, "wr_rd_readmem0", 8'hA5);
    ReadMem = 1'b1;
    read_at(8'h10, "wr_rd_readmem1", 8'hA5);
    ReadMem = 1'b0;

    // WriteMem low must not modify storage
    DataAddress = 8'h10;
    DataIn      = 8'h00;
    @(posedge clk);
    #1;
    check("no_write_when_disabled", DataOut, 8'hA5);

    // Read-before-write at the same address
    dut.mem_core[8'h20] = 8'h11;
    DataAddress = 8'h20;
    DataIn      = 8'h22;
    WriteMem    = 1'b1;
    #1;
    check("rbw_before_edge", DataOut, 8'h11);
    @(posedge clk);
    #1;
    WriteMem = 1'b0;
    check("rbw_after_edge", DataOut, 8'h22);

    // Reset preservation across a 2-cycle pulse
    dut.mem_core[P1_IN_LO] = 8'h34;
    dut.mem_core[P1_IN_HI] = 8'h12;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    read_at(P1_IN_LO, "reset_keep_lo", 8'h34);
    read_at(P1_IN_HI, "reset_keep_hi", 8'h12);

    // Write during reset suppressed, then resumes once reset drops
    dut.mem_core[5] = 8'h00;
    reset = 1'b1;
    write_word(8'h05, 8'hFF);
    check("write_in_reset_ignored", DataOut, 8'h00);
    reset = 1'b0;
    write_word(8'h05, 8'hFF);
    check("write_after_reset", DataOut, 8'hFF);

    // Boundary addresses, no aliasing between top and bottom
    write_word(8'hFF, 8'h5A);
    write_word(8'h00, 8'hC3);
    read_at(8'hFF, "boundary_ff", 8'h5A);
    read_at(8'h00, "boundary_00", 8'hC3);
    read_at(8'h10, "no_alias_10", 8'hA5);

    // Hierarchical writes show up without a clock edge
    DataAddress = P1_OUT_HI;
    #1;
    dut.mem_core[P1_OUT_HI] = 8'h3C;
    dut.mem_core[P1_OUT_LO] = 8'h00;
    #1;
    check("hier_out_hi", DataOut, 8'h3C);
    DataAddress = P1_OUT_LO;
    #1;
    check("hier_out_lo", DataOut, 8'h00);
    dut.mem_core[P1_OUT_LO] = 8'h7E;
    #1;
    check("hier_live_update", DataOut, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
